// File: rtl/ps2_ascii_decoder.sv
// PS/2 keyboard receiver: conditions the raw lines, frames Set-2 bytes and
// turns accepted make codes into single-cycle ASCII events (idle value 8'h2A).
module ps2_ascii_decoder #(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 10000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] ascii_code,
  output logic       key_valid,
  output logic       frame_err
);

  localparam int unsigned FW = $clog2(FILTER_LEN + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0]  IDLE_CODE = 8'h2A;

  typedef enum logic [1:0] {
    ST_NORMAL,
    ST_EXT,
    ST_BREAK,
    ST_EXT_BREAK
  } state_t;

  logic          r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
  logic          r_filt;
  logic [FW-1:0] r_fcnt;
  logic          r_fall;
  logic          r_bit;
  logic          w_flip;

  logic [3:0]    r_bitcnt;
  logic [9:0]    r_shift;
  logic [TW-1:0] r_to;
  logic          r_rx_stb, r_rx_err;
  logic [7:0]    r_rx_byte;
  logic [10:0]   w_frame;
  logic          w_to_hit;

  state_t        r_state, w_state_nxt;
  logic [8:0]    r_last, w_last_nxt;
  logic          w_ev_valid;
  logic [7:0]    w_ev_ascii;
  logic [8:0]    w_map;
  logic          r_ev_valid, r_ev_err;
  logic [7:0]    r_ev_ascii;

  // Input conditioning: 2-flop synchronizers and a level filter on the clock.
  assign w_flip = (r_clk_s2 != r_filt) && (r_fcnt == FW'(FILTER_LEN - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_clk_s1 <= 1'b1;
      r_clk_s2 <= 1'b1;
      r_dat_s1 <= 1'b1;
      r_dat_s2 <= 1'b1;
      r_filt   <= 1'b1;
      r_fcnt   <= '0;
      r_fall   <= 1'b0;
      r_bit    <= 1'b1;
    end else begin
      r_clk_s1 <= ps2_clk;
      r_clk_s2 <= r_clk_s1;
      r_dat_s1 <= ps2_data;
      r_dat_s2 <= r_dat_s1;
      if (r_clk_s2 != r_filt) begin
        if (w_flip) begin
          r_filt <= r_clk_s2;
          r_fcnt <= '0;
        end else begin
          r_fcnt <= r_fcnt + FW'(1);
        end
      end else begin
        r_fcnt <= '0;
      end
      r_fall <= w_flip & r_filt;
      if (w_flip & r_filt) r_bit <= r_dat_s2;
    end
  end

  // Frame layout once the stop bit arrives: [0] start, [8:1] data, [9] parity, [10] stop.
  assign w_frame  = {r_bit, r_shift};
  assign w_to_hit = (r_to == TW'(TIMEOUT_CYCLES)) && !r_fall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bitcnt  <= '0;
      r_shift   <= '0;
      r_to      <= '0;
      r_rx_stb  <= 1'b0;
      r_rx_err  <= 1'b0;
      r_rx_byte <= '0;
    end else begin
      r_rx_stb <= 1'b0;
      r_rx_err <= 1'b0;
      if (r_fall) begin
        r_to <= '0;
        if (r_bitcnt == 4'd10) begin
          r_bitcnt <= '0;
          if (!w_frame[0] && w_frame[10] && (^w_frame[9:1])) begin
            r_rx_stb  <= 1'b1;
            r_rx_byte <= w_frame[8:1];
          end else begin
            r_rx_err <= 1'b1;
          end
        end else begin
          r_shift  <= {r_bit, r_shift[9:1]};
          r_bitcnt <= r_bitcnt + 4'd1;
        end
      end else if (w_to_hit) begin
        r_bitcnt <= '0;
        r_to     <= '0;
      end else if (r_bitcnt != 4'd0) begin
        r_to <= r_to + TW'(1);
      end
    end
  end

  // Make-code map: {hit, ascii}.
  always_comb begin
    w_map = {1'b0, IDLE_CODE};
    if (r_state == ST_EXT) begin
      if (r_rx_byte == 8'h5A) w_map = {1'b1, 8'h0D};
    end else begin
      case (r_rx_byte)
        8'h45: w_map = {1'b1, 8'h30};
        8'h16: w_map = {1'b1, 8'h31};
        8'h1E: w_map = {1'b1, 8'h32};
        8'h26: w_map = {1'b1, 8'h33};
        8'h25: w_map = {1'b1, 8'h34};
        8'h2E: w_map = {1'b1, 8'h35};
        8'h36: w_map = {1'b1, 8'h36};
        8'h3D: w_map = {1'b1, 8'h37};
        8'h3E: w_map = {1'b1, 8'h38};
        8'h46: w_map = {1'b1, 8'h39};
        8'h32: w_map = {1'b1, 8'h62};
        8'h21: w_map = {1'b1, 8'h63};
        8'h1D: w_map = {1'b1, 8'h77};
        8'h2C: w_map = {1'b1, 8'h74};
        8'h15: w_map = {1'b1, 8'h71};
        8'h5A: w_map = {1'b1, 8'h0D};
        8'h66: w_map = {1'b1, 8'h08};
        default: w_map = {1'b0, IDLE_CODE};
      endcase
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last;
    w_ev_valid  = 1'b0;
    w_ev_ascii  = IDLE_CODE;
    if (r_rx_err || w_to_hit) begin
      w_state_nxt = ST_NORMAL;
      w_last_nxt  = '0;
    end else if (r_rx_stb) begin
      case (r_state)
        ST_NORMAL, ST_EXT: begin
          w_state_nxt = ST_NORMAL;
          if (r_rx_byte == 8'hF0) begin
            w_state_nxt = (r_state == ST_EXT) ? ST_EXT_BREAK : ST_BREAK;
          end else if (r_rx_byte == 8'hE0 && r_state == ST_NORMAL) begin
            w_state_nxt = ST_EXT;
          end else if (w_map[8] && ({r_state == ST_EXT, r_rx_byte} != r_last)) begin
            w_ev_valid = 1'b1;
            w_ev_ascii = w_map[7:0];
            w_last_nxt = {r_state == ST_EXT, r_rx_byte};
          end
        end
        ST_BREAK, ST_EXT_BREAK: begin
          w_state_nxt = ST_NORMAL;
          if ({r_state == ST_EXT_BREAK, r_rx_byte} == r_last) w_last_nxt = '0;
        end
        default: w_state_nxt = ST_NORMAL;
      endcase
    end
  end

  // Decoder result is staged once more so every event shares one latency.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_NORMAL;
      r_last     <= '0;
      r_ev_valid <= 1'b0;
      r_ev_ascii <= IDLE_CODE;
      r_ev_err   <= 1'b0;
      ascii_code <= IDLE_CODE;
      key_valid  <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_last     <= w_last_nxt;
      r_ev_valid <= w_ev_valid;
      r_ev_ascii <= w_ev_ascii;
      r_ev_err   <= r_rx_err;
      ascii_code <= r_ev_ascii;
      key_valid  <= r_ev_valid;
      frame_err  <= r_ev_err | w_to_hit;
    end
  end

endmodule

// File: tb/tb_ps2_ascii_decoder.sv
// Scoreboard bench for ps2_ascii_decoder: directed PS/2 frames push expected
// events; an independent monitor pops and checks each output pulse and its timing.
module tb_ps2_ascii_decoder;

  localparam int unsigned FL   = 8;
  localparam int unsigned TO   = 10000;
  localparam int unsigned HALF = 20;
  localparam int unsigned GAP  = 40;

  logic       clk = 1'b0;
  logic       reset;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] ascii_code;
  logic       key_valid;
  logic       frame_err;

  int unsigned cyc = 0;
  int unsigned errors = 0;
  int unsigned checks = 0;

  typedef struct {
    bit          is_err;
    logic [7:0]  ascii;
    int unsigned cyc;
  } exp_t;
  exp_t q[$];

  ps2_ascii_decoder #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
    .clk       (clk),
    .reset     (reset),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .ascii_code(ascii_code),
    .key_valid (key_valid),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // kind: 0 no event, 1 key event with asc, 2 frame error
  task automatic send_frame(input logic [7:0] code, input bit bad_par,
                            input int kind, input logic [7:0] asc);
    logic [10:0] bits;
    bits = {1'b1, (~^code) ^ bad_par, code, 1'b0};
    for (int i = 0; i < 11; i++) begin
      ps2_data = bits[i];
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      if (i == 10 && kind != 0) q.push_back('{kind == 2, asc, cyc + FL + 5});
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    repeat (GAP) @(negedge clk);
  endtask

  task automatic send_partial(input logic [7:0] code, input int nbits,
                              output int unsigned t_last);
    logic [10:0] bits;
    bits = {1'b1, ~^code, code, 1'b0};
    t_last = 0;
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      t_last = cyc;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b1;
    end
  endtask

  initial begin : monitor
    bit   pend;
    exp_t e;
    pend = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        pend = 1'b0;
      end else begin
        if (pend) begin
          chk("idle_after_event", {23'd0, key_valid, ascii_code}, {23'd0, 1'b0, 8'h2A});
          pend = 1'b0;
        end
        if (key_valid || frame_err) begin
          if (q.size() == 0) begin
            chk("unexpected_event", {22'd0, key_valid, frame_err, ascii_code}, 32'd0);
          end else begin
            e = q.pop_front();
            chk("event", {22'd0, key_valid, frame_err, ascii_code},
                {22'd0, !e.is_err, e.is_err, e.is_err ? 8'h2A : e.ascii});
            chk("latency", cyc, e.cyc);
            pend = key_valid;
          end
        end
      end
    end
  end

  initial begin : stim
    int unsigned t;
    reset = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1;
    repeat (5) @(negedge clk);
    chk("reset_ascii", {24'd0, ascii_code}, 32'h2A);
    chk("reset_valid", {31'd0, key_valid}, 32'd0);
    chk("reset_err",   {31'd0, frame_err}, 32'd0);
    reset = 1'b0;
    repeat (10) @(negedge clk);

    send_frame(8'h16, 1'b0, 1, 8'h31);
    send_frame(8'hF0, 1'b0, 0, 8'h00);
    send_frame(8'h16, 1'b0, 0, 8'h00);

    send_frame(8'h1D, 1'b0, 1, 8'h77);
    send_frame(8'h1D, 1'b0, 0, 8'h00);
    send_frame(8'h1D, 1'b0, 0, 8'h00);
    send_frame(8'hF0, 1'b0, 0, 8'h00);
    send_frame(8'h1D, 1'b0, 0, 8'h00);
    send_frame(8'h1D, 1'b0, 1, 8'h77);

    send_frame(8'hE0, 1'b0, 0, 8'h00);
    send_frame(8'h5A, 1'b0, 1, 8'h0D);
    send_frame(8'h5A, 1'b0, 1, 8'h0D);
    send_frame(8'hE0, 1'b0, 0, 8'h00);
    send_frame(8'h75, 1'b0, 0, 8'h00);

    send_frame(8'h45, 1'b1, 2, 8'h00);
    send_frame(8'h45, 1'b0, 1, 8'h30);

    send_partial(8'h15, 5, t);
    q.push_back('{1'b1, 8'h2A, t + FL + TO + 4});
    repeat (TO + FL + 50) @(negedge clk);
    chk("timeout_bitcnt", {28'd0, dut.r_bitcnt}, 32'd0);
    send_frame(8'h15, 1'b0, 1, 8'h71);

    send_partial(8'h5A, 6, t);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("midreset_ascii",  {24'd0, ascii_code}, 32'h2A);
    chk("midreset_valid",  {31'd0, key_valid}, 32'd0);
    chk("midreset_err",    {31'd0, frame_err}, 32'd0);
    chk("midreset_bitcnt", {28'd0, dut.r_bitcnt}, 32'd0);
    ps2_data = 1'b1;
    reset = 1'b0;
    repeat (GAP) @(negedge clk);
    send_frame(8'h5A, 1'b0, 1, 8'h0D);

    ps2_clk = 1'b0;
    repeat (3) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (30) @(negedge clk);
    chk("glitch_bitcnt", {28'd0, dut.r_bitcnt}, 32'd0);

    send_frame(8'h66, 1'b0, 1, 8'h08);
    send_frame(8'h32, 1'b0, 1, 8'h62);
    send_frame(8'h1C, 1'b0, 0, 8'h00);
    send_frame(8'h21, 1'b0, 1, 8'h63);
    send_frame(8'h2C, 1'b0, 1, 8'h74);
    send_frame(8'h46, 1'b0, 1, 8'h39);

    repeat (200) @(negedge clk);
    chk("queue_drained", q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
